instruction_fetch_queue: RTL and testbench
==========================================

# instruction_fetch_queue

Fetch-stage front end for the pipeline processor: owns the fetch PC, drives the combinational instruction-memory address, and buffers fetched words with their PCs in a small FIFO ahead of the IF/ID register. Decouples instruction memory from decode stalls (`hazard_detected_signal`). On a taken branch it redirects fetch and discards everything already queued.

## Interface
Parameters:
- `DEPTH`, default 4: queue entries; power of two, ≥ 2.
- `RESET_PC`, default 32'h0000_0000: fetch PC after reset; low 2 bits must be 0.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_addr`  out  32  fetch PC presented to instruction memory. Equals the current fetch PC register; never gated.
- `imem_data`  in  32  instruction word for `imem_addr`. Combinational, valid in the same cycle.
- `branch_taken`  in  1  redirect request from decode.
- `branch_target`  in  32  redirect address. Bits [1:0] are ignored and forced to 0.
- `stall`  in  1  decode stall, driven by the hazard detection output. While high, the head entry is not consumed.
- `out_valid`  out  1  head entry valid.
- `out_inst`  out  32  head instruction word.
- `out_pc`  out  32  PC of the head instruction.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage: `DEPTH` entries of {pc[31:0], inst[31:0]}, plus read and write pointers of $clog2(DEPTH) bits each. Both pointers wrap modulo `DEPTH`.
- `pop = out_valid & ~stall`.
- `push = ~branch_taken & (count < DEPTH | pop)`.
  - Push writes {fetch_pc, imem_data} at the write pointer.
  - Push then advances fetch_pc by 4, modulo 2^32.
- Flush (`branch_taken` = 1) has priority over push and pop in the same cycle:
  - count ← 0 and both pointers ← 0.
  - fetch_pc ← {branch_target[31:2], 2'b00}.
  - Any concurrent pop and the imem_data for that cycle are discarded.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together, or on neither.
- `out_valid = (count != 0)`.
- `out_inst` and `out_pc` read the entry at the read pointer. They are don't-care when `out_valid` = 0, but must not be X after reset (storage is reset to 0).
- Full (count = DEPTH):
  - No push unless a pop happens the same cycle.
  - fetch_pc holds, and `imem_addr` holds with it.
- Empty (count = 0): pop is impossible. Push still occurs, so the queue fills.
- `stall` alone never affects fetch until the queue is full.
- Reset (asynchronous, at any time, including mid-flush or while full):
  - fetch_pc = `RESET_PC`; count = 0; pointers = 0; storage = 0.
  - `out_valid` = 0; `out_inst` = 0; `out_pc` = 0; `imem_addr` = `RESET_PC`.

## Timing
- All state updates on the rising edge of `clk`; reset acts immediately on assertion.
- Fetch-to-output latency is 1 cycle. A word pushed at edge N is visible on `out_*` after edge N.
- First cycle after reset release: `imem_addr` = `RESET_PC`. After the first edge, `out_valid` = 1 with `out_pc` = `RESET_PC`.
- With `stall` = 0 continuously, the queue holds 1 entry and delivers one instruction per cycle in steady state.
- Redirect: `branch_taken` sampled at edge N.
  - After edge N: `out_valid` = 0 and `imem_addr` = target.
  - After edge N+1: `out_pc` = target.
  - Bubble cost is exactly 1 cycle.
- `out_*` outputs change only on clock edges or reset. `imem_addr` is a direct register output.

## Test plan
- Reset and run: `RESET_PC` = 0x100, `stall` = 0, `imem_data` = addr ^ 0xA5A5A5A5 → consecutive cycles show `out_pc` 0x100, 0x104, 0x108…, with matching `out_inst` and `count` = 1.
- Fill under stall: assert `stall` for 6 cycles from reset, `DEPTH` = 4 → `count` climbs to 4 and saturates. `imem_addr` freezes at 0x110. `out_pc` stays 0x100. Release → 0x100…0x10C drain in order, then 0x110.
- Full with simultaneous push/pop: at `count` = 4, drop `stall` for one cycle → `count` stays 4, `out_pc` advances 0x100→0x104, and fetch_pc advances by 4.
- Branch flush: with 3 entries queued, pulse `branch_taken` with `branch_target` = 0x2003 → next cycle `count` = 0, `out_valid` = 0, `imem_addr` = 0x2000. The cycle after, `out_pc` = 0x2000.
- Branch with stall in the same cycle: `branch_taken` = 1 and `stall` = 1 → flush still occurs. There is no double-pop, and no stale entry appears afterwards.
- Asynchronous reset: assert `reset` mid-cycle while full → outputs go to reset values before the next edge. PC wrap: `RESET_PC` = 0xFFFFFFFC yields `out_pc` 0xFFFFFFFC, then 0x00000000.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// Fetch-stage front end: owns the fetch PC, drives instruction memory and buffers
// fetched {pc, inst} pairs in a small FIFO ahead of decode; a taken branch flushes it.
module instruction_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     branch_taken,
  input  logic [31:0]              branch_target,
  input  logic                     stall,
  output logic                     out_valid,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]     pc_mem_q   [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];

  logic pop;
  logic push;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & ~stall;
  // A full queue still accepts a word when the head drains in the same cycle.
  assign push      = ~branch_taken & ((count_q < CntW'(DEPTH)) | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (branch_taken) begin
      fetch_pc_d = {branch_target[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage is reset so the head outputs are never X, even when invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_data;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_inst  = inst_mem_q[rd_ptr_q];
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: run, fill/stall, full push+pop,
// branch flush (with and without stall), asynchronous reset and PC wrap.
module tb_instruction_fetch_queue;

  localparam logic [31:0] Key = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_inst, out_pc;
  logic [2:0]  count;

  logic [31:0] imem_addr2, imem_data2, out_inst2, out_pc2;
  logic        out_valid2;
  logic [2:0]  count2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word = address ^ key.
  assign imem_data  = imem_addr ^ Key;
  assign imem_data2 = imem_addr2 ^ Key;

  instruction_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .out_valid     (out_valid),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .count         (count)
  );

  instruction_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr2),
    .imem_data     (imem_data2),
    .branch_taken  (1'b0),
    .branch_target (32'h0),
    .stall         (1'b0),
    .out_valid     (out_valid2),
    .out_inst      (out_inst2),
    .out_pc        (out_pc2),
    .count         (count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [2:0] cnt);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".pc"}, out_pc, pc);
    check({tag, ".inst"}, out_inst, pc ^ Key);
    check({tag, ".count"}, 32'(count), 32'(cnt));
  endtask

  initial begin
    reset         = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    stall         = 1'b0;
    #3;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.inst", out_inst, 32'd0);
    check("rst.pc", out_pc, 32'd0);
    check("rst.count", 32'(count), 32'd0);
    check("rst.imem", imem_addr, 32'h100);
    check("rst.imem_wrap", imem_addr2, 32'hFFFF_FFFC);
    tick();
    reset = 1'b0;
    check("first.imem", imem_addr, 32'h100);

    // Free run, one instruction per cycle; wrap instance runs alongside.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_head("run", 32'h100 + 32'(4 * i), 3'd1);
      if (i == 0) check("wrap.pc0", out_pc2, 32'hFFFF_FFFC);
      if (i == 1) check("wrap.pc1", out_pc2, 32'h0000_0000);
      if (i == 1) check("wrap.inst1", out_inst2, Key);
    end

    // Fill under stall: count saturates at 4, fetch freezes at 0x110.
    stall = 1'b1;
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_head("fill", 32'h100, 3'(i > 4 ? 4 : i));
      check("fill.imem", imem_addr, 32'h100 + 32'(4 * (i > 4 ? 4 : i)));
    end

    // One-cycle stall drop while full: push and pop together.
    stall = 1'b0;
    tick();
    stall = 1'b1;
    check_head("fullpp", 32'h104, 3'd4);
    check("fullpp.imem", imem_addr, 32'h114);
    tick();
    check_head("fullpp.hold", 32'h104, 3'd4);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_head("drain", 32'h108 + 32'(4 * i), 3'd4);
    end

    // Branch flush with 3 entries queued.
    stall = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    check("pre_br.count", 32'(count), 32'd3);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_2003;
    stall         = 1'b0;
    tick();
    branch_taken = 1'b0;
    check("br.count", 32'(count), 32'd0);
    check("br.valid", 32'(out_valid), 32'd0);
    check("br.imem", imem_addr, 32'h2000);
    tick();
    check_head("br.after", 32'h2000, 3'd1);

    // Branch together with stall.
    stall = 1'b1;
    tick();
    tick();
    check("brs.pre", 32'(count), 32'd3);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_3000;
    tick();
    branch_taken = 1'b0;
    check("brs.count", 32'(count), 32'd0);
    check("brs.valid", 32'(out_valid), 32'd0);
    check("brs.imem", imem_addr, 32'h3000);
    tick();
    check_head("brs.after1", 32'h3000, 3'd1);
    tick();
    check_head("brs.after2", 32'h3000, 3'd2);
    tick();
    tick();
    check("brs.full", 32'(count), 32'd4);

    // Asynchronous reset mid-cycle while full.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst.valid", 32'(out_valid), 32'd0);
    check("arst.count", 32'(count), 32'd0);
    check("arst.pc", out_pc, 32'd0);
    check("arst.inst", out_inst, 32'd0);
    check("arst.imem", imem_addr, 32'h100);
    #2;
    reset = 1'b0;
    stall = 1'b0;
    tick();
    check_head("arst.after", 32'h100, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
